sprite_layer_mixer: RTL
=======================

// Module: sprite_layer_mixer
// PURPOSE
//  Parametrised per-pixel compositor for the VGA path. Replaces hand-unrolled per-object address/priority logic.
//  Holds NUM_SPR sprite descriptors, double-buffered and committed at frame start (no tearing).
//  Generates ROM addresses for every sprite, applies colour-key transparency and index priority over a background.
//  Reports per-frame sprite-overlap collisions.
//  Sits between vgac (pix_x/pix_y) and the sprite/background ROMs; out_color feeds vga_data.
// PARAMETERS
//  NUM_SPR   8        number of sprite channels; higher index = higher priority
//  XW        10       pixel x width
//  YW        9        pixel y width
//  SW        7        sprite width/height field width
//  AW        14       sprite ROM address width
//  BAW       19       background ROM address width
//  CW        12       colour width (RGB444)
//  KEY_COLOR 12'h428  transparent colour
//  BG_W      551      background width (px)
//  BG_H      401      background height (px)
//  FILL      12'h000  colour outside background
// PORTS
//  clk          in   1             system clock
//  rstn         in   1             synchronous reset, active low
//  frame_start  in   1             1-cycle pulse, start of frame
//  cfg_we       in   1             descriptor write strobe
//  cfg_idx      in   IW            sprite index, IW=$clog2(NUM_SPR)
//  cfg_en       in   1             sprite enable
//  cfg_x        in   XW            sprite top-left x
//  cfg_y        in   YW            sprite top-left y
//  cfg_w        in   SW            sprite width, >=1
//  cfg_h        in   SW            sprite height, >=1
//  cfg_base     in   AW            ROM base address of sprite frame
//  pix_valid    in   1             pixel request valid
//  pix_x        in   XW            pixel column
//  pix_y        in   YW            pixel row
//  spr_addr     out  NUM_SPR*AW    ROM addresses, channel i at [i*AW+:AW]
//  spr_data     in   NUM_SPR*CW    ROM data, 1-cycle read latency
//  bg_addr      out  BAW           background ROM address
//  bg_data      in   CW            background data, 1-cycle read latency
//  out_valid    out  1             out_color valid
//  out_color    out  CW            composited pixel
//  out_top      out  IW+1          winning sprite index; NUM_SPR = background/fill
//  coll_frame   out  NUM_SPR       sprites overlapped (opaque) during last frame
// BEHAVIOUR
//  Reset (rstn=0 at clk edge):
//   - pending+active descriptors cleared (en=0).
//   - spr_addr=0, bg_addr=0, out_valid=0, out_color=FILL, out_top=NUM_SPR, coll_frame=0.
//   - Accumulator cleared; pipeline valid bits cleared. Reset mid-frame drops in-flight pixels.
//  Config:
//   - cfg_we writes the pending descriptor [cfg_idx]. Active set unchanged.
//   - frame_start copies pending->active.
//   - A write in the same cycle as frame_start lands in pending only; it becomes visible at the next frame_start.
//   - cfg_idx>=NUM_SPR: write ignored.
//  Pipeline (fixed latency 3, fully pipelined, one pixel/cycle):
//   - S1 (edge after pix_valid): per sprite, hit = en && x<=pix_x<x+w && y<=pix_y<y+h.
//     Comparisons use XW+1/YW+1 bits so no wrap at screen edge.
//   - S1 hit: spr_addr = base+(pix_y-y)*w+(pix_x-x), truncated to AW. Miss: spr_addr = base.
//   - S1: bg_addr = pix_y*BG_W+pix_x if pix_x<BG_W && pix_y<BG_H, else 0.
//     Hit/in-bg flags and valid are pipelined alongside.
//   - S2: ROM data returns; opaque[i] = hit[i] && spr_data[i]!=KEY_COLOR.
//   - S3 (registered out):
//     - out_color = data of highest-index opaque sprite; else bg_data if in-bg; else FILL.
//     - out_top = that index or NUM_SPR.
//     - out_valid = pix_valid delayed 3 cycles. When out_valid=0, out_color/out_top hold.
//  Collision:
//   - Each S3-valid pixel with >=2 opaque sprites ORs their bits into the accumulator.
//   - frame_start: coll_frame <= accumulator; accumulator <= that cycle's contribution only.
//   - frame_start must not be asserted while pix_valid=1 (caller guarantees).
//  Active descriptor change at frame_start affects pixels issued on or after the next cycle.
// TESTING
//  - Reset, then pix_valid sweep -> out_valid rises exactly 3 clk after the first pix_valid; out_top=NUM_SPR; out_color=bg_data.
//  - Sprite 0 (x=10,y=20,w=47,h=41,base=0), pixel (12,21) -> spr_addr[0]=49; ROM 12'hF00 -> out_color=12'hF00, out_top=0.
//  - Sprites 1 and 3 overlap, both opaque -> out_top=3. Next frame_start -> coll_frame=8'b0000_1010.
//  - Sprite 3 returns 12'h428 over sprite 1 -> out_top=1, no collision bit set.
//  - cfg_we with frame_start in the same cycle -> old descriptor used all frame; new one after the following frame_start.
//  - Sprite x=540,w=47, pixel x=1023 -> no hit (no wrap). Pixel (600,10) -> bg_addr=0, out_color=FILL.

Source files
------------

// File: rtl/sprite_layer_mixer.sv
// sprite_layer_mixer: per-pixel sprite compositor with double-buffered descriptors and collision reporting
module sprite_layer_mixer #(
    parameter int NUM_SPR = 8,
    parameter int XW = 10,
    parameter int YW = 9,
    parameter int SW = 7,
    parameter int AW = 14,
    parameter int BAW = 19,
    parameter int CW = 12,
    parameter logic [CW-1:0] KEY_COLOR = 12'h428,
    parameter int BG_W = 551,
    parameter int BG_H = 401,
    parameter logic [CW-1:0] FILL = 12'h000,
    parameter int IW = $clog2(NUM_SPR)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  frame_start,
    input  logic                  cfg_we,
    input  logic [IW-1:0]         cfg_idx,
    input  logic                  cfg_en,
    input  logic [XW-1:0]         cfg_x,
    input  logic [YW-1:0]         cfg_y,
    input  logic [SW-1:0]         cfg_w,
    input  logic [SW-1:0]         cfg_h,
    input  logic [AW-1:0]         cfg_base,
    input  logic                  pix_valid,
    input  logic [XW-1:0]         pix_x,
    input  logic [YW-1:0]         pix_y,
    output logic [NUM_SPR*AW-1:0] spr_addr,
    input  logic [NUM_SPR*CW-1:0] spr_data,
    output logic [BAW-1:0]        bg_addr,
    input  logic [CW-1:0]         bg_data,
    output logic                  out_valid,
    output logic [CW-1:0]         out_color,
    output logic [IW:0]           out_top,
    output logic [NUM_SPR-1:0]    coll_frame
);
    typedef struct packed {
        logic          en;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [SW-1:0] w;
        logic [SW-1:0] h;
        logic [AW-1:0] base;
    } desc_t;

    desc_t pend [NUM_SPR];
    desc_t act  [NUM_SPR];
    logic [NUM_SPR-1:0]    hit_d, hit1, hit2, opaque, contrib, acc;
    logic [NUM_SPR*AW-1:0] addr_d;
    logic                  inbg_d, inbg1, inbg2, v1, v2;
    logic [IW:0]           top_d;
    logic [CW-1:0]         col_d;
    logic                  idx_ok;

    assign idx_ok = {1'b0, cfg_idx} < (IW+1)'(NUM_SPR);
    assign inbg_d = pix_x < XW'(BG_W) && pix_y < YW'(BG_H);

    // Pending descriptors take writes; frame_start commits the whole set to active
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_SPR; i++) begin
                pend[i] <= '0;
                act[i]  <= '0;
            end
        end else begin
            if (frame_start) act <= pend;
            if (cfg_we && idx_ok) pend[cfg_idx] <= '{cfg_en, cfg_x, cfg_y, cfg_w, cfg_h, cfg_base};
        end
    end

    // Hit test with one extra bit so x+w / y+h never wrap, plus ROM address per sprite
    always_comb begin
        hit_d  = '0;
        addr_d = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            hit_d[i] = act[i].en
                && {1'b0, pix_x} >= {1'b0, act[i].x} && {1'b0, pix_x} < {1'b0, act[i].x} + (XW+1)'(act[i].w)
                && {1'b0, pix_y} >= {1'b0, act[i].y} && {1'b0, pix_y} < {1'b0, act[i].y} + (YW+1)'(act[i].h);
            addr_d[i*AW+:AW] = hit_d[i]
                ? act[i].base + AW'(pix_y - act[i].y) * AW'(act[i].w) + AW'(pix_x - act[i].x)
                : act[i].base;
        end
    end

    // Priority select over opaque sprites (later index wins), background, then fill
    always_comb begin
        top_d = (IW+1)'(NUM_SPR);
        col_d = inbg2 ? bg_data : FILL;
        for (int i = 0; i < NUM_SPR; i++) begin
            opaque[i] = hit2[i] && spr_data[i*CW+:CW] != KEY_COLOR;
            top_d     = opaque[i] ? (IW+1)'(i) : top_d;
            col_d     = opaque[i] ? spr_data[i*CW+:CW] : col_d;
        end
        contrib = (v2 && (opaque & (opaque - NUM_SPR'(1))) != '0) ? opaque : '0;
    end

    // Three-stage pixel pipeline: addresses, ROM wait, registered composite
    always_ff @(posedge clk) begin
        if (!rstn) begin
            spr_addr  <= '0;
            bg_addr   <= '0;
            hit1      <= '0;
            hit2      <= '0;
            inbg1     <= 1'b0;
            inbg2     <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_color <= FILL;
            out_top   <= (IW+1)'(NUM_SPR);
        end else begin
            spr_addr  <= addr_d;
            bg_addr   <= inbg_d ? BAW'(pix_y) * BAW'(BG_W) + BAW'(pix_x) : '0;
            hit1      <= hit_d;
            inbg1     <= inbg_d;
            v1        <= pix_valid;
            hit2      <= hit1;
            inbg2     <= inbg1;
            v2        <= v1;
            out_valid <= v2;
            out_color <= v2 ? col_d : out_color;
            out_top   <= v2 ? top_d : out_top;
        end
    end

    // Collision accumulator; frame_start publishes it and restarts with this cycle's contribution
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc        <= '0;
            coll_frame <= '0;
        end else begin
            acc        <= frame_start ? contrib : acc | contrib;
            coll_frame <= frame_start ? acc : coll_frame;
        end
    end
endmodule
